// File: rtl/div_clk_checker.sv
// Divided-clock checker: measures rising-edge periods of mon_clk in clk cycles,
// checks consecutive period pairs against the programmed 2x ratio and reports
// lock and fault strobes.
// Optional build macro: DIV_CHK_ERR_CNT_EN adds a saturating err_cnt output.
module div_clk_checker #(
  parameter int unsigned MUL2_DIV = 7,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_clk,
  output logic             locked,
  output logic             err_pulse,
`ifdef DIV_CHK_ERR_CNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic [CNT_W-1:0] period_last,
  output logic [CNT_W:0]   pair_sum
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSync  = 2'd1;
  localparam logic [1:0] StMeasA = 2'd2;
  localparam logic [1:0] StMeasB = 2'd3;

  // Odd ratios allow two period lengths, even ratios collapse to one.
  localparam logic [CNT_W-1:0] PLo        = CNT_W'(MUL2_DIV >> 1);
  localparam logic [CNT_W-1:0] PHi        = CNT_W'((MUL2_DIV + 1) >> 1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(2 * MUL2_DIV);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   PairTarget = (CNT_W + 1)'(MUL2_DIV);
  localparam logic [3:0]       LockCnt    = 4'(LOCK_CNT);

  logic             s1_q, s2_q;
  logic             rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pa_q, pa_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] period_last_q, period_last_d;
  logic [CNT_W:0]   pair_sum_q, pair_sum_d;
  logic [CNT_W:0]   pair_calc;
  logic [3:0]       good_inc;
  logic             pa_ok, pb_ok;

  assign rise      = s1_q & ~s2_q;
  assign pair_calc = {1'b0, pa_q} + {1'b0, cnt_q};
  assign good_inc  = (good_cnt_q < LockCnt) ? good_cnt_q + 4'd1 : good_cnt_q;
  assign pa_ok     = (cnt_q == PLo) || (cnt_q == PHi);
  assign pb_ok     = (pa_q == PLo) || (pa_q == PHi);

  // Next-state: period counter, FSM, pair evaluation and fault handling.
  always_comb begin
    state_d       = state_q;
    pa_d          = pa_q;
    good_cnt_d    = good_cnt_q;
    locked_d      = locked_q;
    err_d         = 1'b0;
    period_last_d = period_last_q;
    pair_sum_d    = pair_sum_q;

    if (rise) begin
      cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    end

    if (!en) begin
      // Disable wins over any rise or evaluation in the same cycle.
      state_d    = StIdle;
      cnt_d      = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: state_d = StSync;
        StSync: if (rise) state_d = StMeasA;
        StMeasA: begin
          if (rise) begin
            period_last_d = cnt_q;
            if (pa_ok) begin
              pa_d    = cnt_q;
              state_d = StMeasB;
            end else begin
              err_d      = 1'b1;
              good_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end else if (cnt_q >= TimeoutCnt) begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = StSync;
          end
        end
        StMeasB: begin
          if (rise) begin
            period_last_d = cnt_q;
            pair_sum_d    = pair_calc;
            state_d       = StMeasA;
            if (pa_ok && pb_ok && (pair_calc == PairTarget)) begin
              good_cnt_d = good_inc;
              locked_d   = (good_inc == LockCnt);
            end else begin
              err_d      = 1'b1;
              good_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end else if (cnt_q >= TimeoutCnt) begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            state_d    = StSync;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      pa_q          <= '0;
      good_cnt_q    <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      period_last_q <= '0;
      pair_sum_q    <= '0;
    end else begin
      s1_q          <= mon_clk;
      s2_q          <= s1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pa_q          <= pa_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      period_last_q <= period_last_d;
      pair_sum_q    <= pair_sum_d;
    end
  end

`ifdef DIV_CHK_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating fault counter; survives en toggling, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign locked      = locked_q;
  assign err_pulse   = err_q;
  assign period_last = period_last_q;
  assign pair_sum    = pair_sum_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: ratio 3.5 and ratio 4 instances.
module tb_div_clk_checker;

  logic       clk = 1'b0;
  logic       rst, en7, en8, mon7, mon8;
  logic       locked7, err7, locked8, err8;
  logic [7:0] plast7, plast8;
  logic [8:0] psum7, psum8;
`ifdef DIV_CHK_ERR_CNT_EN
  logic [15:0] ecnt7, ecnt8;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int errs7 = 0;
  int errs8 = 0;

  always #5 clk = ~clk;

  div_clk_checker #(.MUL2_DIV(7), .CNT_W(8), .LOCK_CNT(4)) dut7 (
    .clk         (clk),
    .rst         (rst),
    .en          (en7),
    .mon_clk     (mon7),
    .locked      (locked7),
    .err_pulse   (err7),
`ifdef DIV_CHK_ERR_CNT_EN
    .err_cnt     (ecnt7),
`endif
    .period_last (plast7),
    .pair_sum    (psum7)
  );

  div_clk_checker #(.MUL2_DIV(8), .CNT_W(8), .LOCK_CNT(4)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .en          (en8),
    .mon_clk     (mon8),
    .locked      (locked8),
    .err_pulse   (err8),
`ifdef DIV_CHK_ERR_CNT_EN
    .err_cnt     (ecnt8),
`endif
    .period_last (plast8),
    .pair_sum    (psum8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    errs7 += int'(err7);
    errs8 += int'(err8);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One mon_clk period of p cycles, high for the first ceil(p/2) cycles.
  task automatic per(input int which, input int p);
    for (int i = 0; i < p; i++) begin
      if (which == 7) mon7 = (i < (p + 1) / 2);
      else            mon8 = (i < (p + 1) / 2);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; en7 = 1'b0; en8 = 1'b0; mon7 = 1'b0; mon8 = 1'b0;
    tick(); tick();
    chk("rst_locked", 32'(locked7), 0);
    chk("rst_err", 32'(err7), 0);
    chk("rst_period_last", 32'(plast7), 0);
    chk("rst_pair_sum", 32'(psum7), 0);
    rst = 1'b0;
    en7 = 1'b1;
    tick();

    // Ideal 3.5 divider: calls 1..9 alternate 4,3; lock on rise 9.
    for (int c = 1; c <= 8; c++) per(7, (c % 2 == 1) ? 4 : 3);
    chk("prelock_locked", 32'(locked7), 0);
    chk("prelock_pair_sum", 32'(psum7), 7);
    per(7, 4);
    chk("lock_locked", 32'(locked7), 1);
    chk("lock_pair_sum", 32'(psum7), 7);
    chk("lock_period_last", 32'(plast7), 3);
    chk("lock_no_err", 32'(errs7), 0);

    // Inject a 5-cycle period; it lands in the MEAS_A slot.
    per(7, 3);
    per(7, 5);
    mon7 = 1'b1; tick();
    chk("inj_pre_err", 32'(err7), 0);
    chk("inj_pre_locked", 32'(locked7), 1);
    mon7 = 1'b1; tick();
    chk("inj_err", 32'(err7), 1);
    chk("inj_locked_drop", 32'(locked7), 0);
    chk("inj_period_last", 32'(plast7), 5);
    mon7 = 1'b0; tick();
    chk("inj_err_single", 32'(err7), 0);
    mon7 = 1'b0; tick();
    for (int c = 13; c <= 19; c++) per(7, (c % 2 == 1) ? 3 : 4);
    chk("relock_pending", 32'(locked7), 0);
    per(7, 4);
    chk("relock_locked", 32'(locked7), 1);
    chk("relock_errs", 32'(errs7), 1);

    // Stuck-low mon_clk: timeout fires once, on the 12th held cycle.
    mon7 = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk($sformatf("timeout_err_t%0d", t), 32'(err7), (t == 12) ? 1 : 0);
    end
    chk("timeout_locked", 32'(locked7), 0);
    chk("timeout_errs", 32'(errs7), 2);
`ifdef DIV_CHK_ERR_CNT_EN
    chk("timeout_err_cnt", 32'(ecnt7), 2);
`endif

    // From SYNC: two rises put the FSM in MEAS_B, then reset mid-pair.
    per(7, 4);
    per(7, 3);
    chk("pre_rst_period_last", 32'(plast7), 4);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_locked", 32'(locked7), 0);
    chk("mid_rst_err", 32'(err7), 0);
    chk("mid_rst_period_last", 32'(plast7), 0);
    chk("mid_rst_pair_sum", 32'(psum7), 0);
`ifdef DIV_CHK_ERR_CNT_EN
    chk("mid_rst_err_cnt", 32'(ecnt7), 0);
`endif
    tick();
    per(7, 4);
    chk("post_rst_sync_plast", 32'(plast7), 0);
    per(7, 3);
    chk("post_rst_first_plast", 32'(plast7), 4);
    chk("post_rst_no_pair", 32'(psum7), 0);
    per(7, 4);
    chk("post_rst_pair_sum", 32'(psum7), 7);
    chk("post_rst_plast", 32'(plast7), 3);
    for (int c = 4; c <= 8; c++) per(7, (c % 2 == 1) ? 4 : 3);
    chk("post_rst_prelock", 32'(locked7), 0);
    per(7, 4);
    chk("post_rst_locked", 32'(locked7), 1);

    // Disable while locked: lock drops, no fault strobe.
    en7 = 1'b0;
    tick();
    chk("en_drop_locked", 32'(locked7), 0);
    chk("en_drop_err", 32'(err7), 0);
    tick(); tick();
    chk("en_drop_errs", 32'(errs7), 2);

    // Ratio 4: single legal period; lock after 4 pairs of 4,4.
    en8 = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) per(8, 4);
    chk("r8_prelock", 32'(locked8), 0);
    per(8, 3);
    chk("r8_locked", 32'(locked8), 1);
    chk("r8_pair_sum", 32'(psum8), 8);
    chk("r8_no_err", 32'(errs8), 0);
    per(8, 5);
    chk("r8_p3_errs", 32'(errs8), 1);
    chk("r8_p3_locked", 32'(locked8), 0);
    chk("r8_p3_plast", 32'(plast8), 3);
    per(8, 4);
    chk("r8_p5_errs", 32'(errs8), 2);
    chk("r8_p5_plast", 32'(plast8), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_clk_checker.md
Name: div_clk_checker

Overview:
- Receive-side companion to the team's integer and half-integer clock dividers.
- Samples a divided clock generated from clk and measures rising-edge-to-rising-edge periods in clk cycles.
- Checks consecutive period pairs against the programmed ratio, then reports lock and errors.
- Sits next to each divider instance as a built-in self-check.

Parameters:
- MUL2_DIV, 7, twice the divide ratio (7 = divide-by-3.5); legal range 4..127.
- CNT_W, 8, period counter width; must hold 2*MUL2_DIV.
- LOCK_CNT, 4, consecutive good pairs required before locked asserts; legal range 1..15.

Ports:
- clk  input  1  source clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  enables checking; 0 forces IDLE.
- mon_clk  input  1  divided clock under test, derived from clk.
- locked  output  1  ratio confirmed.
- err_pulse  output  1  one-cycle strobe per detected fault.
- period_last  output  CNT_W  most recent measured period, in clk cycles.
- pair_sum  output  CNT_W+1  sum of the last completed period pair.

Behaviour:
- Reset: rst=1 at a posedge clears the following, visible after that edge:
  - all outputs to 0;
  - sync flops s1/s2 to 0;
  - counter to 0;
  - good_cnt to 0;
  - state to IDLE.
- rst mid-measurement discards any partial pair.
- Sampling: s1<=mon_clk, s2<=s1; rise = s1 & ~s2. mon_clk first sampled 1 at edge k gives rise in cycle k..k+1; all reactions are registered at edge k+1.
- Legal period set: P_LO = MUL2_DIV>>1, P_HI = (MUL2_DIV+1)>>1. For 7 this is {3,4}; for even ratios it is one value.
- Period counter: on rise, cnt<=1; otherwise cnt<=cnt+1, saturating at 2^CNT_W-1. On rise, the captured period = cnt+... precisely, the value of cnt in the rise cycle. period_last is loaded with it.
- FSM states:
  - IDLE: en=0; cnt held 0; locked=0. en=1 -> SYNC.
  - SYNC: wait for the first rise (phase reference; no period captured) -> MEAS_A.
  - MEAS_A: on rise, capture period into pa -> MEAS_B.
  - MEAS_B: on rise, capture pb; pair_sum<=pa+pb; evaluate -> MEAS_A.
- Pair evaluation: pair is good iff pa and pb are each in {P_LO,P_HI} and pa+pb == MUL2_DIV. Either phase order (3,4 or 4,3) is accepted.
  - Good pair: good_cnt increments, saturating at LOCK_CNT. locked<=1 when the new good_cnt == LOCK_CNT.
  - Bad pair: err_pulse=1 for one cycle; good_cnt<=0; locked<=0.
- Period out of range in MEAS_A: flagged immediately with err_pulse, good_cnt and locked cleared, state stays MEAS_A with pa discarded.
- Timeout: in MEAS_A/MEAS_B, cnt reaching 2*MUL2_DIV without a rise (stuck mon_clk) gives:
  - err_pulse;
  - locked<=0, good_cnt<=0;
  - state -> SYNC.
- Timeout is not checked in SYNC.
- en falling: next edge -> IDLE, locked<=0, no err_pulse. This takes priority over a simultaneous rise or evaluation.
- Simultaneous rise and timeout in the same cycle: the rise wins and is measured normally.
- err_pulse never asserts two consecutive cycles from one fault.

Optional Feature:
- DIV_CHK_ERR_CNT_EN defined: adds output err_cnt [15:0].
  - Increments on every err_pulse and saturates at 16'hFFFF.
  - Cleared by rst only, not by en.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- MUL2_DIV=7, en=1, mon_clk from an ideal 3.5 divider (alternating 4/3-cycle periods) -> pair_sum=7 each pair; locked=1 registered after the 4th good pair (9th rise); err_pulse never 1.
- Locked, then one 5-cycle period injected -> err_pulse one cycle, locked=0 the same edge; locked returns after 4 further good pairs.
- Locked, then mon_clk held 0 for 20 cycles -> err_pulse once when cnt=14, FSM in SYNC; no further err_pulse until mon_clk toggles.
- MUL2_DIV=8: periods 4,4 -> locked after 4 pairs; then a 3,5 pair (sum 8) -> err_pulse since 3 is outside {4}.
- rst=1 for one edge mid-MEAS_B -> all outputs 0 next cycle; first pair after reset is not evaluated until SYNC plus two rises.
- en deasserted while locked -> locked=0 next edge, no err_pulse; with DIV_CHK_ERR_CNT_EN, err_cnt keeps its prior value (e.g. 2).
